// File: rtl/fft_peak_reader.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_reader
// Description : Scans a bin window of the FFT result memory after each
//               transform and reports the bin with the largest |re|+|im|.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = 255,
  parameter int MIN_MAG   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_fft_done,
  output logic                   o_rd_en,
  output logic [N-1:0]           o_rd_add,
  input  logic [2*BIT_WIDTH-1:0] i_rd_data,
  output logic                   o_busy,
  output logic                   o_peak_valid,
  output logic                   o_peak_found,
  output logic [N-1:0]           o_peak_bin,
  output logic [BIT_WIDTH:0]     o_peak_mag
);

  // Window end is clamped to the non-mirrored half of the spectrum.
  localparam int            c_max_int = (MAX_BIN < FFT_SIZE/2) ? MAX_BIN : FFT_SIZE/2 - 1;
  localparam logic [N-1:0]  c_min_bin = N'(MIN_BIN);
  localparam logic [N-1:0]  c_max_bin = N'(c_max_int);
  localparam logic [BIT_WIDTH:0] c_min_mag = (BIT_WIDTH+1)'(MIN_MAG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_rd_en;
  logic [N-1:0]       r_rd_add;
  logic               r_busy;
  logic               r_peak_valid;
  logic               r_peak_found;
  logic [N-1:0]       r_peak_bin;
  logic [BIT_WIDTH:0] r_peak_mag;
  logic               r_cmp_valid;
  logic               r_cmp_first;
  logic [N-1:0]       r_cmp_bin;
  logic [N-1:0]       r_best_bin;
  logic [BIT_WIDTH:0] r_best_mag;

  logic signed [BIT_WIDTH-1:0] w_re;
  logic signed [BIT_WIDTH-1:0] w_im;
  logic [BIT_WIDTH:0]          w_abs_re;
  logic [BIT_WIDTH:0]          w_abs_im;
  logic [BIT_WIDTH:0]          w_mag;
  logic                        w_take;
  logic [N-1:0]                w_best_bin_nxt;
  logic [BIT_WIDTH:0]          w_best_mag_nxt;

  assign w_re = i_rd_data[2*BIT_WIDTH-1:BIT_WIDTH];
  assign w_im = i_rd_data[BIT_WIDTH-1:0];

  // One extra bit lets |-2^(W-1)| and the full sum fit without wrapping.
  assign w_abs_re = w_re[BIT_WIDTH-1] ? (~{1'b1, w_re} + 1'b1) : {1'b0, w_re};
  assign w_abs_im = w_im[BIT_WIDTH-1] ? (~{1'b1, w_im} + 1'b1) : {1'b0, w_im};
  assign w_mag    = w_abs_re + w_abs_im;

  always_comb begin
    w_take         = r_cmp_valid && (r_cmp_first || (w_mag > r_best_mag));
    w_best_bin_nxt = r_best_bin;
    w_best_mag_nxt = r_best_mag;
    if (w_take) begin
      w_best_bin_nxt = r_cmp_bin;
      w_best_mag_nxt = w_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_rd_add     <= '0;
      r_busy       <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_found <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_cmp_valid  <= 1'b0;
      r_cmp_first  <= 1'b0;
      r_cmp_bin    <= '0;
      r_best_bin   <= '0;
      r_best_mag   <= '0;
    end else begin
      r_peak_valid <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_best_bin   <= w_best_bin_nxt;
      r_best_mag   <= w_best_mag_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_fft_done) begin
            r_state  <= S_READ;
            r_rd_en  <= 1'b1;
            r_rd_add <= c_min_bin;
            r_busy   <= 1'b1;
          end
        end
        S_READ: begin
          // Tag the address just issued; its data is compared next cycle.
          r_cmp_valid <= 1'b1;
          r_cmp_bin   <= r_rd_add;
          r_cmp_first <= (r_rd_add == c_min_bin);
          if (r_rd_add == c_max_bin) begin
            r_state  <= S_FLUSH;
            r_rd_en  <= 1'b0;
            r_rd_add <= '0;
          end else begin
            r_rd_add <= r_rd_add + 1'b1;
          end
        end
        S_FLUSH: begin
          r_state      <= S_DONE;
          r_peak_valid <= 1'b1;
          r_peak_bin   <= w_best_bin_nxt;
          r_peak_mag   <= w_best_mag_nxt;
          r_peak_found <= (w_best_mag_nxt >= c_min_mag);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_rd_add     = r_rd_add;
  assign o_busy       = r_busy;
  assign o_peak_valid = r_peak_valid;
  assign o_peak_found = r_peak_found;
  assign o_peak_bin   = r_peak_bin;
  assign o_peak_mag   = r_peak_mag;

endmodule
`default_nettype wire

// File: doc/fft_peak_reader.md
# fft_peak_reader

- Reads the FFT result memory after each transform and reports the dominant frequency bin.
- Consumes the FFT output side and is the counterpart of the sample buffering that feeds the FFT input.
- Scans a configurable bin window, forms a magnitude estimate per bin and tracks the running maximum.
- Presents the peak bin and magnitude to the note-detection and SPI reporting logic.

## Interface
Parameters:
- BIT_WIDTH, 16, width of each signed real/imag component
- N, 9, address width (log2 FFT_SIZE)
- FFT_SIZE, 512, transform length
- MIN_BIN, 1, first bin scanned (skips DC)
- MAX_BIN, 255, last bin scanned (≤ FFT_SIZE/2 − 1; MIN_BIN ≤ MAX_BIN)
- MIN_MAG, 64, magnitude threshold for declaring a valid peak

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low; clock clk
- fft_done  in  1  one-cycle pulse from the FFT: result memory complete
- rd_en  out  1  read strobe to result memory
- rd_add  out  N  result memory address
- rd_data  in  2*BIT_WIDTH  {re, im}, both two's complement, re in upper half; registered read, valid 1 cycle after rd_add
- busy  out  1  scan in progress
- peak_valid  out  1  one-cycle pulse: new result on peak_* outputs
- peak_found  out  1  peak_mag ≥ MIN_MAG
- peak_bin  out  N  bin index of maximum
- peak_mag  out  BIT_WIDTH+1  magnitude of maximum, unsigned

## Operation
- States: IDLE, READ, FLUSH, DONE.
  - IDLE → READ when fft_done=1.
  - READ → FLUSH after address MAX_BIN is issued.
  - FLUSH → DONE unconditionally.
  - DONE → IDLE unconditionally.
- READ:
  - rd_en=1; rd_add steps MIN_BIN, MIN_BIN+1, …, MAX_BIN, one per cycle, no stalls.
- Magnitude:
  - mag = |re| + |im|, computed unsigned at BIT_WIDTH+1 bits; no saturation is needed.
  - |−2^(BIT_WIDTH−1)| = 2^(BIT_WIDTH−1); the maximum is 2^BIT_WIDTH = 65536 at default width.
- Compare:
  - Evaluated in the cycle rd_data is valid, i.e. during READ cycles 2..L and during FLUSH.
  - The first bin of a scan unconditionally loads the internal best registers.
  - Afterwards, best is replaced only if mag > best_mag (strictly greater), so ties keep the lowest bin.
- DONE:
  - peak_bin, peak_mag and peak_found are loaded from the internal best registers.
  - peak_valid=1 for exactly this cycle.
  - Outputs hold until the next DONE or reset.
- Bins outside [MIN_BIN, MAX_BIN] are never read and cannot influence the result.
- fft_done is ignored while busy=1: it neither restarts nor queues a scan.
- Reset asserted mid-scan:
  - Next state is IDLE and all outputs return to reset values.
  - No peak_valid is produced for the aborted scan.
- Reset values: rd_en=0, rd_add=0, busy=0, peak_valid=0, peak_found=0, peak_bin=0, peak_mag=0.
- rd_add=0 and rd_en=0 in IDLE, FLUSH and DONE.

## Timing
- L = MAX_BIN − MIN_BIN + 1; L = 255 at defaults.
- fft_done sampled high at edge k (state IDLE):
  - READ occupies cycles k+1 … k+L, with rd_add = MIN_BIN+i in cycle k+1+i.
  - FLUSH occupies cycle k+L+1, where the last bin is compared.
  - DONE occupies cycle k+L+2, with peak_valid high.
  - The block is back in IDLE at k+L+3.
- Latency from fft_done to peak_valid is L+2 cycles: 257 at defaults.
- busy is high in READ, FLUSH and DONE, and low in IDLE.
- A fft_done pulse in the cycle the block returns to IDLE (k+L+3) is accepted, so back-to-back scans are L+3 cycles apart.
- Memory contents must remain stable from k+1 through k+L+1.

## Test plan
- Tone at bin 37 ({re,im}={1000,−500}); all other bins {10,10}; pulse fft_done → peak_valid exactly 257 cycles later, peak_bin=37, peak_mag=1500, peak_found=1.
- Equal maxima: bins 20 and 40 both {300,300} → peak_bin=20, peak_mag=600.
- Window exclusion: bin 0 and bin 300 {30000,30000}, bin 128 {200,0} → peak_bin=128, peak_mag=200.
- All-zero memory → peak_bin=1 (MIN_BIN), peak_mag=0, peak_found=0. Threshold edge: single bin {64,0} → found=1; {63,0} → found=0.
- Extremes: bin 100 {−32768,−32768} → peak_mag=65536, no wrap; bin 101 {32767,32767} → peak_bin stays 100.
- Control robustness:
  - Second fft_done pulse at cycle k+50 → ignored; only one peak_valid appears, at k+257.
  - reset low at k+100 → IDLE next cycle, all outputs 0, no peak_valid.
  - Fresh fft_done afterwards completes normally.
